// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the conv_mac_acc accumulator slice.
package conv_acc_pkg;

  localparam logic [1:0] CAL_FMT_INT8  = 2'b00;
  localparam logic [1:0] CAL_FMT_INT16 = 2'b01;
  localparam logic [1:0] CAL_FMT_FP16  = 2'b10;

  typedef logic [1:0] cal_fmt_t;

  localparam int unsigned ACC_W_DEF  = 48;
  localparam int unsigned MAC_FRAC_W = 40;
  localparam int unsigned EXP_W      = 8;

  // INT8 and the reserved code run on the integer path.
  function automatic logic is_fp_fmt(input cal_fmt_t fmt);
    logic fp;
    case (fmt)
      CAL_FMT_INT8:  fp = 1'b0;
      CAL_FMT_INT16: fp = 1'b0;
      CAL_FMT_FP16:  fp = 1'b1;
      default:       fp = 1'b0;
    endcase
    return fp;
  endfunction

endpackage

// File: rtl/conv_acc_align_add.sv
// Combinational align-and-add: exponent compare, clamped arithmetic shift of
// the smaller-exponent operand, add. Macro CONV_MAC_ACC_SAT_EN selects a
// saturating adder; otherwise the sum wraps.
module conv_acc_align_add
  import conv_acc_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             is_fp,
  input  logic [EXP_W-1:0] acc_exp,
  input  logic [ACC_W-1:0] acc_frac,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [ACC_W-1:0] in_frac,
  output logic [EXP_W-1:0] sum_exp_c,
  output logic [ACC_W-1:0] sum_frac_c
);

  logic             in_big;
  logic [EXP_W-1:0] d;
  logic [ACC_W-1:0] small_op;
  logic [ACC_W-1:0] big_op;
  logic [ACC_W-1:0] shifted;
  logic [ACC_W-1:0] add_a;
  logic [ACC_W-1:0] add_b;
`ifdef CONV_MAC_ACC_SAT_EN
  logic [ACC_W:0]   sum_ext;
`endif

  // Align operands, add, then apply the FP zero-operand shortcuts.
  always_comb begin
    in_big   = (in_exp >= acc_exp);
    d        = in_big ? (in_exp - acc_exp) : (acc_exp - in_exp);
    small_op = in_big ? acc_frac : in_frac;
    big_op   = in_big ? in_frac : acc_frac;
    if (32'(d) >= ACC_W) shifted = {ACC_W{small_op[ACC_W-1]}};
    else                 shifted = ACC_W'($signed(small_op) >>> d);

    add_a     = is_fp ? big_op : acc_frac;
    add_b     = is_fp ? shifted : in_frac;
    sum_exp_c = (is_fp && in_big) ? in_exp : acc_exp;

`ifdef CONV_MAC_ACC_SAT_EN
    sum_ext = {add_a[ACC_W-1], add_a} + {add_b[ACC_W-1], add_b};
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
      sum_frac_c = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sum_frac_c = sum_ext[ACC_W-1:0];
`else
    sum_frac_c = add_a + add_b;
`endif

    if (is_fp && (in_frac == '0)) begin
      sum_frac_c = acc_frac;
      sum_exp_c  = acc_exp;
    end else if (is_fp && (acc_frac == '0)) begin
      sum_frac_c = in_frac;
      sum_exp_c  = in_exp;
    end
  end

endmodule

// File: rtl/conv_mac_acc.sv
// Group accumulator behind conv_mac_cell: sums acc_grp_n_m1+1 consecutive
// partial sums (FP16 exponent-aligned or INT16 fixed-point) into one result.
// Optional macro: CONV_MAC_ACC_SAT_EN (saturating adds).
module conv_mac_acc
  import conv_acc_pkg::*;
#(
  parameter int unsigned ACC_W            = ACC_W_DEF,
  parameter int unsigned INFO_ALONG_WIDTH = 2,
  parameter int          SIM_DELAY        = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        aclken,
  input  logic [1:0]                  calfmt,
  input  logic [7:0]                  acc_grp_n_m1,
  input  logic                        acc_clr,
  input  logic [7:0]                  mac_out_exp,
  input  logic [39:0]                 mac_out_frac,
  input  logic [INFO_ALONG_WIDTH-1:0] mac_out_info_along,
  input  logic                        mac_out_valid,
  output logic [7:0]                  acc_out_exp,
  output logic [ACC_W-1:0]            acc_out_frac,
  output logic [INFO_ALONG_WIDTH-1:0] acc_out_info_along,
  output logic                        acc_out_valid,
  output logic                        acc_busy
);

  // Register delay is a simulation-only notion; not modelled here.
  logic unused_sim_delay_c;
  assign unused_sim_delay_c = (SIM_DELAY != 0);

  logic [7:0]                  cnt_q, cnt_d;
  cal_fmt_t                    fmt_q, fmt_d;
  logic [7:0]                  grp_q, grp_d;
  logic [EXP_W-1:0]            acc_exp_q, acc_exp_d;
  logic [ACC_W-1:0]            acc_frac_q, acc_frac_d;
  logic [EXP_W-1:0]            out_exp_q, out_exp_d;
  logic [ACC_W-1:0]            out_frac_q, out_frac_d;
  logic [INFO_ALONG_WIDTH-1:0] out_info_q, out_info_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;

  logic [7:0]       cnt_eff;
  logic [7:0]       grp_eff;
  cal_fmt_t         fmt_eff;
  logic [ACC_W-1:0] in_frac_ext;
  logic [EXP_W-1:0] sum_exp_c;
  logic [ACC_W-1:0] sum_frac_c;

  assign in_frac_ext = ACC_W'($signed(mac_out_frac));

  conv_acc_align_add #(.ACC_W(ACC_W)) u_align_add (
    .is_fp      (is_fp_fmt(fmt_q)),
    .acc_exp    (acc_exp_q),
    .acc_frac   (acc_frac_q),
    .in_exp     (mac_out_exp),
    .in_frac    (in_frac_ext),
    .sum_exp_c  (sum_exp_c),
    .sum_frac_c (sum_frac_c)
  );

  // Next-state: clear, group start / accumulate, completion and output load.
  always_comb begin
    cnt_d       = cnt_q;
    fmt_d       = fmt_q;
    grp_d       = grp_q;
    acc_exp_d   = acc_exp_q;
    acc_frac_d  = acc_frac_q;
    out_exp_d   = out_exp_q;
    out_frac_d  = out_frac_q;
    out_info_d  = out_info_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    cnt_eff     = acc_clr ? 8'd0 : cnt_q;
    grp_eff     = (cnt_eff == 8'd0) ? acc_grp_n_m1 : grp_q;
    fmt_eff     = (cnt_eff == 8'd0) ? calfmt : fmt_q;

    if (aclken) begin
      out_valid_d = 1'b0;
      if (acc_clr) begin
        cnt_d      = 8'd0;
        acc_exp_d  = '0;
        acc_frac_d = '0;
      end
      if (mac_out_valid) begin
        if (cnt_eff == 8'd0) begin
          fmt_d      = calfmt;
          grp_d      = acc_grp_n_m1;
          acc_exp_d  = mac_out_exp;
          acc_frac_d = in_frac_ext;
        end else begin
          acc_exp_d  = sum_exp_c;
          acc_frac_d = sum_frac_c;
        end
        if (cnt_eff == grp_eff) begin
          cnt_d       = 8'd0;
          out_valid_d = 1'b1;
          out_frac_d  = acc_frac_d;
          out_exp_d   = is_fp_fmt(fmt_eff) ? acc_exp_d : '0;
          out_info_d  = mac_out_info_along;
        end else begin
          cnt_d = 8'(cnt_eff + 8'd1);
        end
      end
      busy_d = (cnt_d != 8'd0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt_q       <= '0;
      fmt_q       <= '0;
      grp_q       <= '0;
      acc_exp_q   <= '0;
      acc_frac_q  <= '0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_info_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fmt_q       <= fmt_d;
      grp_q       <= grp_d;
      acc_exp_q   <= acc_exp_d;
      acc_frac_q  <= acc_frac_d;
      out_exp_q   <= out_exp_d;
      out_frac_q  <= out_frac_d;
      out_info_q  <= out_info_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign acc_out_exp        = out_exp_q;
  assign acc_out_frac       = out_frac_q;
  assign acc_out_info_along = out_info_q;
  assign acc_out_valid      = out_valid_q;
  assign acc_busy           = busy_q;

endmodule
